// File: rtl/fetch_decode_unit.sv
// Fetch/decode control for a two-instruction (ADDI, BNE) RISC-V subset.
// It holds the PC, the RUN/HALT state and the retired count, and decodes
// the current ROM word into register addresses and datapath controls.
module fetch_decode_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADD_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [ADD_WIDTH-1:0]  AD1,
    output logic [ADD_WIDTH-1:0]  AD2,
    output logic [ADD_WIDTH-1:0]  AD3,
    output logic                  WE3,
    output logic                  ALUsrc,
    output logic [DATA_WIDTH-1:0] Immop,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] retired
);

    localparam logic [6:0] OPC_ADDI   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam int unsigned EXT_W     = DATA_WIDTH - 12;
    localparam int unsigned EXT_WB    = DATA_WIDTH - 13;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state;

    logic                  is_addi;
    logic                  is_bne;
    logic                  legal;
    logic                  step;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_b;

    // Instruction classification and immediate formats.
    always_comb begin
        is_addi = (instr[6:0] == OPC_ADDI)   && (instr[14:12] == F3_ADDI);
        is_bne  = (instr[6:0] == OPC_BRANCH) && (instr[14:12] == F3_BNE);
        legal   = is_addi || is_bne;
        imm_i   = {{EXT_W{instr[31]}}, instr[31:20]};
        imm_b   = {{EXT_WB{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
        step    = en && !rst && (state == RUN);
    end

    // Datapath control outputs, valid in the same cycle as pc.
    always_comb begin
        AD1    = ADD_WIDTH'(instr[19:15]);
        AD2    = ADD_WIDTH'(instr[24:20]);
        AD3    = ADD_WIDTH'(instr[11:7]);
        WE3    = 1'b0;
        ALUsrc = 1'b0;
        Immop  = '0;
        if (is_addi) begin
            Immop = imm_i;
        end else if (is_bne) begin
            Immop = imm_b;
        end
        if (state == RUN) begin
            ALUsrc = is_addi;
        end
        if (step && is_addi && (instr[11:7] != 5'd0)) begin
            WE3 = 1'b1;
        end
    end

    // RUN/HALT state, program counter and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            halted  <= 1'b0;
            pc      <= '0;
            retired <= '0;
        end else if (en && (state == RUN)) begin
            if (legal) begin
                if (is_bne && !EQ) begin
                    pc <= pc + imm_b;
                end else begin
                    pc <= pc + DATA_WIDTH'(4);
                end
                retired <= retired + DATA_WIDTH'(1);
            end else begin
                state  <= HALT;
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed program table, hand-written
// halt/enable/reset sequences, then random instructions against a model.
module tb_fetch_decode_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] instr;
    logic        EQ;
    logic [31:0] pc;
    logic [4:0]  AD1;
    logic [4:0]  AD2;
    logic [4:0]  AD3;
    logic        WE3;
    logic        ALUsrc;
    logic [31:0] Immop;
    logic        halted;
    logic [31:0] retired;

    int checks;
    int failures;

    // Reference state
    bit [31:0] m_pc;
    bit [31:0] m_ret;
    bit        m_halt;

    // Combinational outputs sampled by the last step
    logic        s_we3;
    logic        s_alusrc;
    logic [31:0] s_immop;

    typedef struct {
        logic [31:0] instr;
        logic        eq;
        logic        we3;
        logic        alusrc;
        logic [31:0] immop;
        logic [31:0] pc_after;
        logic [31:0] ret_after;
        logic        halt_after;
    } vec_t;

    vec_t vecs[7];

    fetch_decode_unit #(.DATA_WIDTH(32), .ADD_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .en(en), .instr(instr), .EQ(EQ),
        .pc(pc), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3),
        .ALUsrc(ALUsrc), .Immop(Immop), .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_addi(input bit [31:0] i);
        return (i[6:0] == 7'h13) && (i[14:12] == 3'd0);
    endfunction

    function automatic bit is_bne(input bit [31:0] i);
        return (i[6:0] == 7'h63) && (i[14:12] == 3'd1);
    endfunction

    // Signed immediate as a plain integer, then wrapped to 32 bits.
    function automatic bit [31:0] imm_of(input bit [31:0] i);
        int v;
        v = 0;
        if (is_addi(i)) begin
            v = int'(i[31:20]);
            if (v >= 2048) v = v - 4096;
        end else if (is_bne(i)) begin
            v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                + int'(i[11:8]) * 2;
            if (v >= 4096) v = v - 8192;
        end
        return 32'(v);
    endfunction

    // One clock: drive inputs, check decode mid-cycle, check state after edge.
    task automatic step(input logic [31:0] i, input logic e, input logic r, input logic q);
        bit legal;
        bit [31:0] imm;
        instr = i; en = e; rst = r; EQ = q;
        legal = is_addi(i) || is_bne(i);
        imm = imm_of(i);
        @(negedge clk);
        s_we3 = WE3; s_alusrc = ALUsrc; s_immop = Immop;
        chk("WE3", 32'(WE3),
            32'(!r && e && !m_halt && is_addi(i) && (i[11:7] != 5'd0)));
        if (!r) begin
            chk("AD1", 32'(AD1), 32'(i[19:15]));
            chk("AD2", 32'(AD2), 32'(i[24:20]));
            chk("AD3", 32'(AD3), 32'(i[11:7]));
            if (m_halt) begin
                chk("ALUsrc_halt", 32'(ALUsrc), 32'(0));
            end else if (legal) begin
                chk("ALUsrc", 32'(ALUsrc), 32'(is_addi(i)));
                chk("Immop", Immop, imm);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0; m_ret = 0; m_halt = 0;
        end else if (e && !m_halt) begin
            if (!legal) begin
                m_halt = 1;
            end else begin
                m_ret = m_ret + 1;
                if (is_bne(i) && !q) m_pc = m_pc + imm;
                else m_pc = m_pc + 4;
            end
        end
        chk("pc", pc, m_pc);
        chk("retired", retired, m_ret);
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] ADDI_X0 = 32'h00500013;
    localparam logic [31:0] BNE_M4  = 32'hFE209EE3;
    localparam logic [31:0] ILLEGAL = 32'hFFFFFFFF;

    initial begin
        bit [31:0] ri;
        int sel;
        checks = 0; failures = 0;
        m_pc = 0; m_ret = 0; m_halt = 0;
        rst = 1; en = 0; instr = 0; EQ = 0;

        vecs[0] = '{ADDI_X1, 1'b0, 1'b1, 1'b1, 32'd5,        32'd4,  32'd1, 1'b0};
        vecs[1] = '{ADDI_X0, 1'b0, 1'b0, 1'b1, 32'd5,        32'd8,  32'd2, 1'b0};
        vecs[2] = '{BNE_M4,  1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'd4,  32'd3, 1'b0};
        vecs[3] = '{ADDI_X1, 1'b0, 1'b1, 1'b1, 32'd5,        32'd8,  32'd4, 1'b0};
        vecs[4] = '{BNE_M4,  1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'd12, 32'd5, 1'b0};
        vecs[5] = '{ADDI_X1, 1'b0, 1'b1, 1'b1, 32'd5,        32'd16, 32'd6, 1'b0};
        vecs[6] = '{ILLEGAL, 1'b0, 1'b0, 1'b0, 32'd0,        32'd16, 32'd6, 1'b1};

        // Reset state
        step(ADDI_X1, 1'b1, 1'b1, 1'b0);
        chk("rst_we3", 32'(s_we3), 32'(0));
        chk("rst_pc", pc, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_halted", 32'(halted), 32'(0));

        // Directed program
        for (int k = 0; k < 7; k++) begin
            step(vecs[k].instr, 1'b1, 1'b0, vecs[k].eq);
            chk($sformatf("vec%0d_we3", k), 32'(s_we3), 32'(vecs[k].we3));
            if (k != 6) begin
                chk($sformatf("vec%0d_alusrc", k), 32'(s_alusrc), 32'(vecs[k].alusrc));
                chk($sformatf("vec%0d_immop", k), s_immop, vecs[k].immop);
            end
            chk($sformatf("vec%0d_pc", k), pc, vecs[k].pc_after);
            chk($sformatf("vec%0d_ret", k), retired, vecs[k].ret_after);
            chk($sformatf("vec%0d_halt", k), 32'(halted), 32'(vecs[k].halt_after));
        end

        // HALT is sticky, suppresses writes and forces ALUsrc low
        for (int k = 0; k < 3; k++) begin
            step(ADDI_X1, 1'b1, 1'b0, 1'b0);
            chk("halt_we3", 32'(s_we3), 32'(0));
            chk("halt_alusrc", 32'(s_alusrc), 32'(0));
            chk("halt_pc", pc, 32'd16);
            chk("halt_ret", retired, 32'd6);
        end
        step(ADDI_X1, 1'b0, 1'b1, 1'b0);
        chk("unhalt_pc", pc, 32'd0);
        chk("unhalt_halted", 32'(halted), 32'(0));

        // en=0 freezes with a valid ADDI present
        for (int k = 0; k < 3; k++) begin
            step(ADDI_X1, 1'b0, 1'b0, 1'b0);
            chk("hold_we3", 32'(s_we3), 32'(0));
            chk("hold_pc", pc, 32'd0);
            chk("hold_ret", retired, 32'd0);
        end
        step(ADDI_X1, 1'b1, 1'b0, 1'b0);
        chk("resume_pc", pc, 32'd4);
        chk("resume_ret", retired, 32'd1);

        // rst beats en with a taken-branch candidate present
        step(BNE_M4, 1'b1, 1'b1, 1'b0);
        chk("rsten_pc", pc, 32'd0);
        chk("rsten_ret", retired, 32'd0);

        // Random instruction stream
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 99));
            ri = $urandom;
            if (sel < 46) begin
                ri[14:12] = 3'd0; ri[6:0] = 7'h13;
            end else if (sel < 92) begin
                ri[14:12] = 3'd1; ri[6:0] = 7'h63;
            end
            step(ri, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_decode_unit.md
FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the PC, instruction, immediate and counter width.
REQ-002 Parameter ADD_WIDTH, default 5, SHALL set the register-address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 en  input  1  SHALL be the step enable; en=0 freezes all state.
REQ-006 instr  input  DATA_WIDTH  SHALL be the instruction word read combinationally from the instruction ROM at pc.
REQ-007 EQ  input  1  SHALL be the datapath equality flag, high when the ALU operands are equal.
REQ-008 pc  output  DATA_WIDTH  SHALL be the current program counter and the ROM address.
REQ-009 AD1, AD2, AD3  output  ADD_WIDTH each  SHALL be rs1 = instr[19:15], rs2 = instr[24:20] and rd = instr[11:7].
REQ-010 WE3  output  1  SHALL be the register-file write enable.
REQ-011 ALUsrc  output  1  SHALL select Immop (1) or RD2 (0) as the second ALU operand.
REQ-012 Immop  output  DATA_WIDTH  SHALL be the sign-extended immediate.
REQ-013 halted  output  1  SHALL be high in the HALT state.
REQ-014 retired  output  DATA_WIDTH  SHALL count retired instructions.

Function
REQ-015 The FSM SHALL have two states, RUN and HALT; reset enters RUN.
REQ-016 The supported instructions SHALL be:
- ADDI: opcode 0010011, funct3 000.
- BNE: opcode 1100011, funct3 001.
- Every other encoding is illegal.
REQ-017 ADDI decode in RUN SHALL drive:
- ALUsrc=1.
- Immop = sign-extended instr[31:20].
- WE3=1 unless rd=0, in which case WE3=0.
REQ-018 BNE decode in RUN SHALL drive:
- ALUsrc=0.
- WE3=0.
- Immop = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
REQ-019 Decode SHALL be combinational from instr, so control outputs are valid in the same cycle as pc.
REQ-020 The next-PC rule in RUN with en=1 SHALL be:
- BNE with EQ=0: pc <= pc + Immop (branch taken).
- ADDI, or BNE with EQ=1: pc <= pc + 4.
REQ-021 PC arithmetic SHALL be modulo 2^DATA_WIDTH; wrap-around is legal and not flagged.
REQ-022 An illegal instruction in RUN with en=1 SHALL:
- Move the FSM to HALT on that edge.
- Hold pc at the illegal instruction's address.
- Force WE3=0 in that cycle.
- Not increment retired.
REQ-023 In HALT the block SHALL:
- Hold pc and retired.
- Force WE3=0 and ALUsrc=0.
- Leave HALT only via rst.
REQ-024 With en=0, pc, the FSM state and retired SHALL hold, and WE3 SHALL be forced to 0.
REQ-025 retired SHALL increment by 1 per legal instruction executed with en=1 in RUN and SHALL wrap from all-ones to 0.
REQ-026 If rst and en are both high, rst SHALL take priority.

Reset
REQ-027 When rst is high on a rising edge, the block SHALL set pc=0, retired=0, state=RUN and halted=0.
REQ-028 While rst is high, WE3 SHALL be 0 regardless of instr.
REQ-029 A reset asserted mid-program SHALL discard the in-flight instruction; no register write and no count occurs for it.
REQ-030 Outputs other than WE3 during reset SHALL follow combinational decode of instr and carry no meaning.

Verification
REQ-031 Reset then instr=0x00500093 (addi x1,x0,5), en=1 -> AD3=1, AD1=0, ALUsrc=1, Immop=5, WE3=1; next edge pc=4, retired=1.
REQ-032 At pc=8, instr=0xFE209EE3 (bne x1,x2,-4), EQ=0 -> ALUsrc=0, WE3=0, Immop=0xFFFFFFFC; next edge pc=4. Same instruction with EQ=1 -> next edge pc=12.
REQ-033 instr=0x00000093 (addi x1,x0,0)... SHALL use rd=0 instead: instr=0x00500013 -> WE3=0; pc still advances by 4 and retired increments.
REQ-034 instr=0xFFFFFFFF at pc=16 -> next edge halted=1, pc stays 16, retired unchanged; WE3=0 for all following cycles until rst; rst -> pc=0, halted=0.
REQ-035 en=0 for 3 cycles with a valid ADDI present -> pc, retired unchanged and WE3=0 throughout; en=1 -> execution resumes at the same pc.
REQ-036 rst and en both high with a BNE present and EQ=0 -> after the edge pc=0, retired=0 and no branch is taken.
